// File: rtl/skid_fifo.sv
// Parametrised skid FIFO with advisory in_ready, occupancy count, sticky overflow and flush.
// Optional high-water tracking when SKID_FIFO_HWM_EN is defined.
module skid_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SKID  = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
`ifdef SKID_FIFO_HWM_EN
  output logic [$clog2(DEPTH+1)-1:0]   high_water,
`endif
  output logic                         overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] RDY_LIM = CW'(DEPTH-SKID);

  if (SKID >= DEPTH || SKID < 1 || DEPTH < 2) begin : g_bad_cfg
    $error("skid_fifo: need DEPTH >= 2 and 1 <= SKID < DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_nxt;
  logic [PW-1:0]    wr_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             full;
  logic             pop;
  logic             push;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full     = (count == FULL);
    pop      = out_valid & out_ready;
    push     = in_valid & (~full | pop);
    rd_nxt   = pop  ? inc(rd_ptr) : rd_ptr;
    wr_nxt   = push ? inc(wr_ptr) : wr_ptr;
    cnt_nxt  = count + CW'(push) - CW'(pop);
    // the incoming beat becomes the head when nothing older survives
    head_nxt = (push && count == CW'(pop)) ? in_data : mem[rd_nxt];
  end

  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      overflow  <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      rd_ptr    <= rd_nxt;
      wr_ptr    <= wr_nxt;
      count     <= cnt_nxt;
      out_valid <= (cnt_nxt != '0);
      in_ready  <= (cnt_nxt < RDY_LIM);
      if (cnt_nxt != '0) out_data <= head_nxt;
      if (in_valid && full && !pop) overflow <= 1'b1;
    end
  end

`ifdef SKID_FIFO_HWM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      high_water <= '0;
    end else if (flush) begin
      high_water <= '0;
    end else if (count > high_water) begin
      high_water <= count;
    end
  end
`endif

endmodule

// File: tb/tb_skid_fifo.sv
// Bench for skid_fifo: queue-based reference model plus directed scenarios.
// Builds with or without SKID_FIFO_HWM_EN.
module tb_skid_fifo;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int S  = 2;
  localparam int CW = $clog2(D+1);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
  logic          overflow;
`ifdef SKID_FIFO_HWM_EN
  logic [CW-1:0] high_water;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  skid_fifo #(.WIDTH(W), .DEPTH(D), .SKID(S)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count),
`ifdef SKID_FIFO_HWM_EN
    .high_water(high_water),
`endif
    .overflow(overflow)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: a plain queue updated by the interface rules
  logic [W-1:0] mq[$];
  logic [W-1:0] got[$];
  bit           m_ovf = 1'b0;

  always @(posedge clock or negedge reset_n) begin : model
    bit p;
    bit u;
    if (!reset_n) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      p = (mq.size() > 0) && out_ready;
      u = in_valid && (mq.size() < D || p);
      if (!flush && out_valid && out_ready) got.push_back(out_data);
      if (flush) begin
        mq.delete();
      end else begin
        if (!p && in_valid && mq.size() == D) m_ovf = 1'b1;
        if (p) void'(mq.pop_front());
        if (u) mq.push_back(in_data);
      end
    end
  end

  always @(negedge clock) begin : compare
    chk("count", 64'(count), 64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("in_ready", 64'(in_ready), 64'((D - mq.size()) > S));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (mq.size() != 0) chk("out_data", 64'(out_data), 64'(mq[0]));
  end

  task automatic step(input bit iv, input logic [W-1:0] d,
                      input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clock);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #2 reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int base;
    int maxc;
    @(negedge clock);
    chk("rst_count", 64'(count), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_out_data", 64'(out_data), 0);
`ifdef SKID_FIFO_HWM_EN
    chk("rst_high_water", 64'(high_water), 0);
`endif
    #2 reset_n = 1'b1;
    @(negedge clock);

    // fill with backpressure
    step(1, 32'hA, 0, 0);
    chk("t1_ready_c1", 64'(in_ready), 1);
    step(1, 32'hB, 0, 0);
    chk("t1_count_c2", 64'(count), 2);
    chk("t1_ready_c2", 64'(in_ready), 0);
    step(1, 32'hC, 0, 0);
    step(1, 32'hD, 0, 0);
    chk("t1_count_full", 64'(count), 4);
    chk("t1_ovf", 64'(overflow), 0);

    // drop while full
    step(1, 32'hE, 0, 0);
    chk("t2_ovf", 64'(overflow), 1);
    chk("t2_count", 64'(count), 4);
    step(0, 0, 0, 0);
    chk("t2_ovf_sticky", 64'(overflow), 1);
    base = got.size();
    repeat (4) step(0, 0, 1, 0);
    chk("t2_pops", 64'(got.size() - base), 4);
    chk("t2_pop0", 64'(got[base]), 32'hA);
    chk("t2_pop1", 64'(got[base+1]), 32'hB);
    chk("t2_pop2", 64'(got[base+2]), 32'hC);
    chk("t2_pop3", 64'(got[base+3]), 32'hD);
    chk("t2_ovf_after", 64'(overflow), 1);

    // push and pop while full
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'hF0 + i, 0, 0);
    step(1, 32'h5A, 1, 0);
    chk("t3_count", 64'(count), 4);
    chk("t3_ovf", 64'(overflow), 0);
    base = got.size() - 1;
    repeat (4) step(0, 0, 1, 0);
    chk("t3_pops", 64'(got.size() - base), 5);
    chk("t3_first", 64'(got[base]), 32'hF0);
    chk("t3_last", 64'(got[base+4]), 32'h5A);

    // single beat latency, then streaming
    step(1, 32'h77, 0, 0);
    chk("t4_valid", 64'(out_valid), 1);
    chk("t4_data", 64'(out_data), 32'h77);
    base = got.size();
    maxc = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 32'h1000 + i, 1, 0);
      if (int'(count) > maxc) maxc = int'(count);
    end
    chk("t4_rate", 64'(got.size() - base), 100);
    chk("t4_maxcount", 64'(maxc), 1);
    step(0, 0, 1, 0);
    chk("t4_tail", 64'(got[got.size()-1]), 32'h1000 + 99);

    // flush with three entries and a pending beat
    for (int i = 0; i < 5; i++) step(1, 32'h200 + i, 0, 0);
    step(0, 0, 1, 0);
    chk("t5_count_pre", 64'(count), 3);
    chk("t5_ovf_pre", 64'(overflow), 1);
    step(1, 32'h999, 0, 1);
    chk("t5_count", 64'(count), 0);
    chk("t5_valid", 64'(out_valid), 0);
    chk("t5_ready", 64'(in_ready), 1);
    chk("t5_ovf", 64'(overflow), 1);
    step(0, 0, 0, 0);

    // asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) step(1, 32'h300 + i, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_count", 64'(count), 0);
    chk("t6_valid", 64'(out_valid), 0);
    chk("t6_ready", 64'(in_ready), 1);
    chk("t6_ovf", 64'(overflow), 0);
    chk("t6_data", 64'(out_data), 0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
`ifdef SKID_FIFO_HWM_EN
    chk("hwm_reset", 64'(high_water), 0);
    step(1, 32'hA, 0, 0);
    step(1, 32'hB, 0, 0);
    step(1, 32'hC, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("hwm_peak", 64'(high_water), 3);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("hwm_flush", 64'(high_water), 0);
`endif
    step(0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
